// File: rtl/prio_encoder_arb.sv
// Registered priority encoder / arbiter: N-bit request vector to W-bit index.
// Fixed-priority or round-robin selection behind a valid/ready output register.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        request vector, bit k requests index k
//   mode       0 = fixed priority (lowest index), 1 = round-robin
//   out_ready  consumer accepts the current output
//   out_valid  output register holds a valid index
//   out_idx    selected index
//   out_multi  more than one request was set when out_idx was loaded
//   multi_cnt  saturating count of multi-hot loads
module prio_encoder_arb #(
  parameter int N     = 16,
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_idx,
  output logic             out_multi,
  output logic [CNT_W-1:0] multi_cnt
);

  logic             valid_q, valid_d;
  logic [W-1:0]     idx_q, idx_d;
  logic             multi_q, multi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     ptr_q, ptr_d;

  logic             load_en;
  logic [N-1:0]     ge_mask;
  logic [N-1:0]     hi_req;
  logic [W-1:0]     fp_idx;
  logic [W-1:0]     rr_idx;
  logic [W-1:0]     sel_idx;
  logic             is_multi;
  logic             cnt_sat;

  // Index of the lowest set bit; 0 when v is empty.
  function automatic logic [W-1:0] lsb_idx(
    input logic [N-1:0] v
  );
    logic [W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = W'(i);
    end
    return r;
  endfunction

  // Requests at or above the round-robin pointer.
  always_comb begin
    ge_mask = '0;
    for (int k = 0; k < N; k++) begin
      ge_mask[k] = (W'(k) >= ptr_q);
    end
  end

  assign hi_req = req & ge_mask;
  assign fp_idx = lsb_idx(req);

  // Nothing at/above ptr: wrap to the lowest request overall.
  assign rr_idx = (|hi_req) ? lsb_idx(hi_req) : fp_idx;

  assign sel_idx = mode ? rr_idx : fp_idx;

  // Clearing the lowest set bit leaves something only if multi-hot.
  assign is_multi = |(req & (req - N'(1)));

  assign cnt_sat = &cnt_q;
  assign load_en = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    multi_d = multi_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      if (|req) begin
        valid_d = 1'b1;
        idx_d   = sel_idx;
        multi_d = is_multi;
        if (mode) begin
          ptr_d = sel_idx + W'(1);
        end
        if (is_multi && !cnt_sat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      multi_q <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      multi_q <= multi_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_multi = multi_q;
  assign multi_cnt = cnt_q;

endmodule

// File: doc/prio_encoder_arb.md
# prio_encoder_arb

Parametrised, registered successor to the 16-to-4 one-hot encoder. Maps an N-bit request vector to a W-bit index and offers two selection modes: fixed priority and round-robin. The output is a registered valid/ready stage. It sits between request-generating logic and any consumer that needs one index per handshake. It also flags multi-hot inputs and keeps a saturating count of them.

## Interface
- `N`, default 16: request width; power of two, ≥ 2.
- `W`, default 4: index width; must equal clog2(N).
- `CNT_W`, default 8: width of the multi-hot event counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N: request vector; bit k requests index k.
- `mode` in 1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- `out_ready` in 1: consumer accepts the current output.
- `out_valid` out 1: output register holds a valid index.
- `out_idx` out W: encoded index of the selected request.
- `out_multi` out 1: more than one `req` bit was set when `out_idx` was loaded.
- `multi_cnt` out CNT_W: number of loads with `out_multi` = 1; saturates.

## Operation
- Define load_en = !out_valid | out_ready. `req` is sampled only on cycles where load_en = 1.
- On load_en with req ≠ 0:
  - `out_valid` ← 1.
  - `out_idx` ← selected index.
  - `out_multi` ← (popcount(req) > 1).
- On load_en with req = 0: `out_valid` ← 0. `out_idx` and `out_multi` hold their old values and are don't-care.
- When load_en = 0 (stall: out_valid & !out_ready), all outputs hold and `req` is ignored.
- Mode 0 selection: lowest set bit of `req`.
- Mode 1 selection:
  - Take the lowest set bit at index ≥ `ptr`.
  - If there is none, take the lowest set bit overall (wrap).
- `ptr` is internal, W bits, reset 0.
  - In mode 1, on every load with req ≠ 0: ptr ← out_idx_next + 1 mod N. The wrap is natural W-bit overflow.
  - In mode 0, `ptr` holds.
- `mode` is sampled with `req`. A mode change affects only the next load; the held output is unaffected.
- `multi_cnt` increments by 1 on each load with popcount(req) > 1. It stays at 2^CNT_W−1 once reached; no wrap.
- Reset has priority over everything, including mid-stall and mid-handshake. Reset values:
  - `out_valid` = 0
  - `out_idx` = 0
  - `out_multi` = 0
  - `multi_cnt` = 0
  - `ptr` = 0

## Timing
- Latency is 1 cycle: `req` sampled at edge t appears on `out_idx`/`out_valid` after edge t.
- Throughput is one index per cycle while `out_ready` = 1.
- A handshake completes on a cycle where out_valid & out_ready. The same edge loads the next `req`, so there are no bubbles.
- `out_ready` may be asserted without `out_valid`; this has no effect beyond load_en.
- Stall: `out_idx`, `out_multi` and `out_valid` are stable from the cycle `out_valid` rises until the handshake completes.
- Cycle after `rst` deasserts: the first `req` sample occurs (load_en = 1 since out_valid = 0).
- All outputs are registered; no combinational path from `req` or `out_ready` to any output.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with req = 16'hFFFF → `out_valid` = 0, `out_idx` = 0, `out_multi` = 0, `multi_cnt` = 0. First load after release gives `out_idx` = 0.
- One-hot sweep: mode 0, out_ready = 1, req = 1<<k for k = 0..15, one per cycle → one cycle later `out_idx` = k, `out_valid` = 1, `out_multi` = 0; `multi_cnt` stays 0.
- Fixed priority, multi-hot: mode 0, req = 16'h8081 → `out_idx` = 0, `out_multi` = 1, `multi_cnt` = 1. Then req = 16'h8000 → `out_idx` = 15, `out_multi` = 0.
- Round-robin fairness: mode 1, req = 16'hFFFF held, out_ready = 1 for 17 cycles → `out_idx` runs 0,1,…,15,0 and `multi_cnt` = 17. With req = 16'h0011 the sequence alternates 0,4,0,4.
- Backpressure: the output holds `out_idx` = 3 with out_ready = 0; change req to 16'h0100 for 3 cycles → `out_idx` stays 3. Raise out_ready → next cycle `out_idx` = 8. Then req = 0 → `out_valid` falls.
- Saturation and reset mid-op:
  - CNT_W = 2, mode 0, req = 16'h0003 for 5 loads → `multi_cnt` = 3 and holds.
  - Assert `rst` during a stall → all outputs return to 0 on the next edge.
